bp_cfg_reg_decoder: RTL and testbench

BP_CFG_REG_DECODER -- requirements
Module: bp_cfg_reg_decoder

---
 rtl/bp_common_cfg_link_pkg.sv | 43 ++++
 rtl/bp_cfg_reg_decoder_if.sv | 24 ++
 rtl/bp_cfg_addr_decode.sv | 49 ++++
 rtl/bp_cfg_reg_decoder.sv | 219 +++++++++++++++++++++
 tb/tb_bp_cfg_reg_decoder.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_common_cfg_link_pkg.sv
// Shared config-link definitions: local register offsets, forwarding windows
// and the forward-target / decoder-state enums.
package bp_common_cfg_link_pkg;

  localparam logic [15:0] bp_cfg_reg_reset_gp       = 16'h0001;
  localparam logic [15:0] bp_cfg_reg_freeze_gp      = 16'h0002;
  localparam logic [15:0] bp_cfg_reg_core_id_gp     = 16'h0005;
  localparam logic [15:0] bp_cfg_reg_icache_mode_gp = 16'h0022;
  localparam logic [15:0] bp_cfg_reg_npc_lo_gp      = 16'h0040;
  localparam logic [15:0] bp_cfg_reg_npc_hi_gp      = 16'h0041;
  localparam logic [15:0] bp_cfg_reg_dcache_mode_gp = 16'h0043;
  localparam logic [15:0] bp_cfg_reg_cce_mode_gp    = 16'h0081;

  localparam logic [15:0] bp_cfg_irf_base_gp   = 16'h0050;
  localparam logic [15:0] bp_cfg_irf_end_gp    = 16'h006f;
  localparam logic [15:0] bp_cfg_frf_base_gp   = 16'h00a0;
  localparam logic [15:0] bp_cfg_frf_end_gp    = 16'h00bf;
  localparam logic [15:0] bp_cfg_csr_base_gp   = 16'h6000;
  localparam logic [15:0] bp_cfg_csr_end_gp    = 16'h6fff;
  localparam logic [15:0] bp_cfg_ucode_base_gp = 16'h8000;
  localparam logic [15:0] bp_cfg_ucode_end_gp  = 16'h8fff;

  typedef enum logic [1:0] {
    e_cfg_sel_irf   = 2'd0,
    e_cfg_sel_frf   = 2'd1,
    e_cfg_sel_csr   = 2'd2,
    e_cfg_sel_ucode = 2'd3
  } bp_cfg_fwd_sel_e;

  typedef enum logic [1:0] {
    e_ready    = 2'd0,
    e_fwd_req  = 2'd1,
    e_fwd_wait = 2'd2,
    e_resp     = 2'd3
  } bp_cfg_state_e;

  function automatic logic addr_in_range(input logic [15:0] addr,
                                         input logic [15:0] lo,
                                         input logic [15:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/bp_cfg_reg_decoder_if.sv
// Config-link command/response bundle; master issues commands, slave answers.
interface bp_cfg_reg_decoder_if #(
  parameter int cfg_data_width_p = 32
);
  logic                        cfg_v;
  logic                        cfg_w;
  logic [15:0]                 cfg_addr;
  logic [cfg_data_width_p-1:0] cfg_data;
  logic                        cfg_ready;
  logic                        resp_v;
  logic [cfg_data_width_p-1:0] resp_data;
  logic                        resp_err;
  logic                        resp_yumi;

  modport master (
    output cfg_v, cfg_w, cfg_addr, cfg_data, resp_yumi,
    input  cfg_ready, resp_v, resp_data, resp_err
  );

  modport slave (
    input  cfg_v, cfg_w, cfg_addr, cfg_data, resp_yumi,
    output cfg_ready, resp_v, resp_data, resp_err
  );
endinterface

// File: rtl/bp_cfg_addr_decode.sv
// Pure combinational classification of a config offset into local register,
// forwarded target (with target index) or unmapped.
module bp_cfg_addr_decode
  import bp_common_cfg_link_pkg::*;
(
  input  logic [15:0]     addr_i,
  output logic            local_o,
  output logic            fwd_o,
  output logic            err_o,
  output bp_cfg_fwd_sel_e sel_o,
  output logic [11:0]     idx_o
);

  always_comb begin
    local_o = 1'b0;
    fwd_o   = 1'b0;
    sel_o   = e_cfg_sel_irf;
    idx_o   = '0;

    case (addr_i)
      bp_cfg_reg_reset_gp, bp_cfg_reg_freeze_gp, bp_cfg_reg_core_id_gp,
      bp_cfg_reg_icache_mode_gp, bp_cfg_reg_dcache_mode_gp,
      bp_cfg_reg_cce_mode_gp, bp_cfg_reg_npc_lo_gp, bp_cfg_reg_npc_hi_gp:
        local_o = 1'b1;
      default: ;
    endcase

    if (addr_in_range(addr_i, bp_cfg_irf_base_gp, bp_cfg_irf_end_gp)) begin
      fwd_o = 1'b1;
      sel_o = e_cfg_sel_irf;
      idx_o = 12'(addr_i - bp_cfg_irf_base_gp);
    end else if (addr_in_range(addr_i, bp_cfg_frf_base_gp, bp_cfg_frf_end_gp)) begin
      fwd_o = 1'b1;
      sel_o = e_cfg_sel_frf;
      idx_o = 12'(addr_i - bp_cfg_frf_base_gp);
    end else if (addr_in_range(addr_i, bp_cfg_csr_base_gp, bp_cfg_csr_end_gp)) begin
      fwd_o = 1'b1;
      sel_o = e_cfg_sel_csr;
      idx_o = addr_i[11:0];
    end else if (addr_in_range(addr_i, bp_cfg_ucode_base_gp, bp_cfg_ucode_end_gp)) begin
      fwd_o = 1'b1;
      sel_o = e_cfg_sel_ucode;
      idx_o = addr_i[11:0];
    end

    err_o = ~local_o & ~fwd_o;
  end

endmodule

// File: rtl/bp_cfg_reg_decoder.sv
// Config-link register decoder: serves local core-control registers and
// forwards irf/frf/csr/ucode accesses, one transaction at a time.
module bp_cfg_reg_decoder
  import bp_common_cfg_link_pkg::*;
#(
  parameter int cfg_data_width_p = 32,
  parameter int vaddr_width_p    = 39,
  parameter int core_id_width_p  = 4,
  parameter logic [vaddr_width_p-1:0] npc_reset_p = 'h0080000000
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic                        cfg_v_i,
  input  logic                        cfg_w_i,
  input  logic [15:0]                 cfg_addr_i,
  input  logic [cfg_data_width_p-1:0] cfg_data_i,
  output logic                        cfg_ready_o,

  output logic                        resp_v_o,
  output logic [cfg_data_width_p-1:0] resp_data_o,
  output logic                        resp_err_o,
  input  logic                        resp_yumi_i,

  output logic                        reset_o,
  output logic                        freeze_o,
  output logic [core_id_width_p-1:0]  core_id_o,
  output logic [1:0]                  icache_mode_o,
  output logic [1:0]                  dcache_mode_o,
  output logic                        cce_mode_o,
  output logic [vaddr_width_p-1:0]    npc_o,

  output logic                        fwd_v_o,
  output logic                        fwd_w_o,
  output logic [1:0]                  fwd_sel_o,
  output logic [11:0]                 fwd_idx_o,
  output logic [cfg_data_width_p-1:0] fwd_data_o,
  input  logic                        fwd_ready_i,
  input  logic                        fwd_rdata_v_i,
  input  logic [cfg_data_width_p-1:0] fwd_rdata_i
);

  bp_cfg_state_e               state_q, state_d;
  logic                        reset_q, reset_d;
  logic                        freeze_q, freeze_d;
  logic [core_id_width_p-1:0]  core_id_q, core_id_d;
  logic [1:0]                  icache_q, icache_d;
  logic [1:0]                  dcache_q, dcache_d;
  logic                        cce_q, cce_d;
  logic [vaddr_width_p-1:0]    npc_q, npc_d;
  logic                        resp_err_q, resp_err_d;
  logic [cfg_data_width_p-1:0] resp_data_q, resp_data_d;
  logic                        fwd_w_q, fwd_w_d;
  bp_cfg_fwd_sel_e             fwd_sel_q, fwd_sel_d;
  logic [11:0]                 fwd_idx_q, fwd_idx_d;
  logic [cfg_data_width_p-1:0] fwd_data_q, fwd_data_d;

  logic                        dec_local, dec_fwd, dec_err;
  bp_cfg_fwd_sel_e             dec_sel;
  logic [11:0]                 dec_idx;
  logic [cfg_data_width_p-1:0] rd_val;
  logic                        accept;

  bp_cfg_addr_decode u_decode (
    .addr_i  (cfg_addr_i),
    .local_o (dec_local),
    .fwd_o   (dec_fwd),
    .err_o   (dec_err),
    .sel_o   (dec_sel),
    .idx_o   (dec_idx)
  );

  // Zero-extended view of the addressed local register for reads.
  always_comb begin
    rd_val = '0;
    case (cfg_addr_i)
      bp_cfg_reg_reset_gp:       rd_val[0] = reset_q;
      bp_cfg_reg_freeze_gp:      rd_val[0] = freeze_q;
      bp_cfg_reg_core_id_gp:     rd_val[core_id_width_p-1:0] = core_id_q;
      bp_cfg_reg_icache_mode_gp: rd_val[1:0] = icache_q;
      bp_cfg_reg_dcache_mode_gp: rd_val[1:0] = dcache_q;
      bp_cfg_reg_cce_mode_gp:    rd_val[0] = cce_q;
      bp_cfg_reg_npc_lo_gp:      rd_val[31:0] = npc_q[31:0];
      bp_cfg_reg_npc_hi_gp:      rd_val[vaddr_width_p-33:0] = npc_q[vaddr_width_p-1:32];
      default: ;
    endcase
  end

  assign cfg_ready_o = (state_q == e_ready);
  assign accept      = cfg_v_i & cfg_ready_o;

  always_comb begin
    state_d     = state_q;
    reset_d     = reset_q;
    freeze_d    = freeze_q;
    core_id_d   = core_id_q;
    icache_d    = icache_q;
    dcache_d    = dcache_q;
    cce_d       = cce_q;
    npc_d       = npc_q;
    resp_err_d  = resp_err_q;
    resp_data_d = resp_data_q;
    fwd_w_d     = fwd_w_q;
    fwd_sel_d   = fwd_sel_q;
    fwd_idx_d   = fwd_idx_q;
    fwd_data_d  = fwd_data_q;

    case (state_q)
      e_ready: begin
        if (accept) begin
          if (dec_local) begin
            state_d     = e_resp;
            resp_err_d  = 1'b0;
            resp_data_d = cfg_w_i ? '0 : rd_val;
            if (cfg_w_i) begin
              case (cfg_addr_i)
                bp_cfg_reg_reset_gp:       reset_d   = cfg_data_i[0];
                bp_cfg_reg_freeze_gp:      freeze_d  = cfg_data_i[0];
                bp_cfg_reg_core_id_gp:     core_id_d = cfg_data_i[core_id_width_p-1:0];
                bp_cfg_reg_icache_mode_gp: icache_d  = cfg_data_i[1:0];
                bp_cfg_reg_dcache_mode_gp: dcache_d  = cfg_data_i[1:0];
                bp_cfg_reg_cce_mode_gp:    cce_d     = cfg_data_i[0];
                // The PC may only be changed while the core is frozen.
                bp_cfg_reg_npc_lo_gp:
                  if (freeze_q) npc_d[31:0] = cfg_data_i[31:0];
                  else          resp_err_d  = 1'b1;
                bp_cfg_reg_npc_hi_gp:
                  if (freeze_q) npc_d[vaddr_width_p-1:32] = cfg_data_i[vaddr_width_p-33:0];
                  else          resp_err_d  = 1'b1;
                default: ;
              endcase
            end
          end else if (dec_fwd) begin
            state_d    = e_fwd_req;
            fwd_w_d    = cfg_w_i;
            fwd_sel_d  = dec_sel;
            fwd_idx_d  = dec_idx;
            fwd_data_d = cfg_data_i;
          end else if (dec_err) begin
            state_d     = e_resp;
            resp_err_d  = 1'b1;
            resp_data_d = '0;
          end
        end
      end
      e_fwd_req: begin
        if (fwd_ready_i) begin
          if (fwd_w_q) begin
            state_d     = e_resp;
            resp_err_d  = 1'b0;
            resp_data_d = '0;
          end else begin
            state_d = e_fwd_wait;
          end
        end
      end
      e_fwd_wait: begin
        if (fwd_rdata_v_i) begin
          state_d     = e_resp;
          resp_err_d  = 1'b0;
          resp_data_d = fwd_rdata_i;
        end
      end
      e_resp: begin
        if (resp_yumi_i) state_d = e_ready;
      end
      default: state_d = e_ready;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= e_ready;
      reset_q    <= 1'b1;
      freeze_q   <= 1'b1;
      core_id_q  <= '0;
      icache_q   <= '0;
      dcache_q   <= '0;
      cce_q      <= 1'b0;
      npc_q      <= npc_reset_p;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      reset_q    <= reset_d;
      freeze_q   <= freeze_d;
      core_id_q  <= core_id_d;
      icache_q   <= icache_d;
      dcache_q   <= dcache_d;
      cce_q      <= cce_d;
      npc_q      <= npc_d;
      resp_err_q <= resp_err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    resp_data_q <= resp_data_d;
    fwd_w_q     <= fwd_w_d;
    fwd_sel_q   <= fwd_sel_d;
    fwd_idx_q   <= fwd_idx_d;
    fwd_data_q  <= fwd_data_d;
  end

  assign resp_v_o      = (state_q == e_resp);
  assign resp_data_o   = resp_data_q;
  assign resp_err_o    = resp_err_q;
  assign fwd_v_o       = (state_q == e_fwd_req);
  assign fwd_w_o       = fwd_w_q;
  assign fwd_sel_o     = fwd_sel_q;
  assign fwd_idx_o     = fwd_idx_q;
  assign fwd_data_o    = fwd_data_q;
  assign reset_o       = reset_q;
  assign freeze_o      = freeze_q;
  assign core_id_o     = core_id_q;
  assign icache_mode_o = icache_q;
  assign dcache_mode_o = dcache_q;
  assign cce_mode_o    = cce_q;
  assign npc_o         = npc_q;

endmodule

// File: tb/tb_bp_cfg_reg_decoder.sv
// Scoreboard bench for bp_cfg_reg_decoder: local registers, forwarding,
// unmapped offsets, response back-pressure and mid-transaction reset.
module tb_bp_cfg_reg_decoder;
  import bp_common_cfg_link_pkg::*;

  localparam logic [38:0] NPC_RST = 39'h0080000000;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic        clk;
  logic        reset_i;
  logic        reset_o, freeze_o, cce_mode_o;
  logic [3:0]  core_id_o;
  logic [1:0]  icache_mode_o, dcache_mode_o;
  logic [38:0] npc_o;
  logic        fwd_v_o, fwd_w_o;
  logic [1:0]  fwd_sel_o;
  logic [11:0] fwd_idx_o;
  logic [31:0] fwd_data_o;
  logic        fwd_ready_i, fwd_rdata_v_i;
  logic [31:0] fwd_rdata_i;

  bp_cfg_reg_decoder_if #(.cfg_data_width_p(32)) cfg_if ();

  bp_cfg_reg_decoder dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .cfg_v_i       (cfg_if.cfg_v),
    .cfg_w_i       (cfg_if.cfg_w),
    .cfg_addr_i    (cfg_if.cfg_addr),
    .cfg_data_i    (cfg_if.cfg_data),
    .cfg_ready_o   (cfg_if.cfg_ready),
    .resp_v_o      (cfg_if.resp_v),
    .resp_data_o   (cfg_if.resp_data),
    .resp_err_o    (cfg_if.resp_err),
    .resp_yumi_i   (cfg_if.resp_yumi),
    .reset_o       (reset_o),
    .freeze_o      (freeze_o),
    .core_id_o     (core_id_o),
    .icache_mode_o (icache_mode_o),
    .dcache_mode_o (dcache_mode_o),
    .cce_mode_o    (cce_mode_o),
    .npc_o         (npc_o),
    .fwd_v_o       (fwd_v_o),
    .fwd_w_o       (fwd_w_o),
    .fwd_sel_o     (fwd_sel_o),
    .fwd_idx_o     (fwd_idx_o),
    .fwd_data_o    (fwd_data_o),
    .fwd_ready_i   (fwd_ready_i),
    .fwd_rdata_v_i (fwd_rdata_v_i),
    .fwd_rdata_i   (fwd_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   fwd_cnt = 0;
  exp_t sb[$];

  always @(posedge clk) if (fwd_v_o) fwd_cnt <= fwd_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic w, input logic [15:0] addr, input logic [31:0] data,
                      input logic [31:0] exp_d, input logic exp_e);
    int n;
    exp_t x;
    cfg_if.cfg_v    = 1'b1;
    cfg_if.cfg_w    = w;
    cfg_if.cfg_addr = addr;
    cfg_if.cfg_data = data;
    n = 0;
    while (!cfg_if.cfg_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cfg_if.cfg_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    cfg_if.cfg_v = 1'b0;
    x.d = exp_d;
    x.e = exp_e;
    sb.push_back(x);
  endtask

  task automatic get_resp(input int hold);
    int   n;
    logic [31:0] d0;
    logic e0;
    exp_t x;
    n = 0;
    while (!cfg_if.resp_v && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cfg_if.resp_v) begin
      chk("resp_timeout", 0, 1);
      return;
    end
    d0 = cfg_if.resp_data;
    e0 = cfg_if.resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_v", cfg_if.resp_v, 1);
      chk("hold_data", cfg_if.resp_data, d0);
      chk("hold_err", cfg_if.resp_err, e0);
      chk("hold_ready", cfg_if.cfg_ready, 0);
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      x = sb.pop_front();
      chk("resp_data", cfg_if.resp_data, x.d);
      chk("resp_err", cfg_if.resp_err, x.e);
    end
    chk("ready_during_resp", cfg_if.cfg_ready, 0);
    cfg_if.resp_yumi = 1'b1;
    @(posedge clk); #1;
    cfg_if.resp_yumi = 1'b0;
    chk("resp_v_after_yumi", cfg_if.resp_v, 0);
    chk("ready_after_yumi", cfg_if.cfg_ready, 1);
  endtask

  // Serve one forwarded request: check fields, stall, then complete it.
  task automatic fwd_serve(input logic [1:0] sel, input logic [11:0] idx, input logic w,
                           input logic [31:0] wdata, input int delay, input logic [31:0] rdata);
    chk("fwd_v", fwd_v_o, 1);
    chk("fwd_sel", fwd_sel_o, sel);
    chk("fwd_idx", fwd_idx_o, idx);
    chk("fwd_w", fwd_w_o, w);
    if (w) chk("fwd_data", fwd_data_o, wdata);
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
      chk("fwd_hold_v", fwd_v_o, 1);
      chk("fwd_hold_sel", fwd_sel_o, sel);
      chk("fwd_hold_idx", fwd_idx_o, idx);
      chk("fwd_busy_ready", cfg_if.cfg_ready, 0);
    end
    fwd_ready_i = 1'b1;
    @(posedge clk); #1;
    fwd_ready_i = 1'b0;
    chk("fwd_v_drop", fwd_v_o, 0);
    if (!w) begin
      @(posedge clk); #1;
      chk("wait_no_resp", cfg_if.resp_v, 0);
      fwd_rdata_v_i = 1'b1;
      fwd_rdata_i   = rdata;
      @(posedge clk); #1;
      fwd_rdata_v_i = 1'b0;
      fwd_rdata_i   = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] la [5];
    logic [31:0] lw [5];
    logic [31:0] lr [5];
    int c0;
    logic any_resp;

    la = '{16'h0005, 16'h0022, 16'h0043, 16'h0081, 16'h0001};
    lw = '{32'hfffffff3, 32'h6, 32'h1, 32'h3, 32'h0};
    lr = '{32'h3, 32'h2, 32'h1, 32'h1, 32'h0};

    reset_i = 1'b1;
    cfg_if.cfg_v = 1'b0; cfg_if.cfg_w = 1'b0; cfg_if.cfg_addr = '0;
    cfg_if.cfg_data = '0; cfg_if.resp_yumi = 1'b0;
    fwd_ready_i = 1'b0; fwd_rdata_v_i = 1'b0; fwd_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_reset_o", reset_o, 1);
    chk("rst_freeze", freeze_o, 1);
    chk("rst_core_id", core_id_o, 0);
    chk("rst_icache", icache_mode_o, 0);
    chk("rst_dcache", dcache_mode_o, 0);
    chk("rst_cce", cce_mode_o, 0);
    chk("rst_npc", npc_o, NPC_RST);
    chk("rst_fwd_v", fwd_v_o, 0);
    chk("rst_resp_v", cfg_if.resp_v, 0);
    reset_i = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", cfg_if.cfg_ready, 1);

    // npc writes while frozen
    send(1'b1, 16'h0040, 32'h80001000, 32'h0, 1'b0);
    get_resp(0);
    send(1'b1, 16'h0041, 32'h1, 32'h0, 1'b0);
    get_resp(0);
    chk("npc_frozen_wr", npc_o, 39'h0180001000);
    send(1'b0, 16'h0040, 32'h0, 32'h80001000, 1'b0);
    chk("local_rd_latency", cfg_if.resp_v, 1);
    get_resp(0);
    send(1'b0, 16'h0041, 32'h0, 32'h1, 1'b0);
    get_resp(0);

    // unfreeze, read back
    send(1'b1, 16'h0002, 32'h0, 32'h0, 1'b0);
    chk("freeze_after_accept", freeze_o, 0);
    get_resp(0);
    send(1'b0, 16'h0002, 32'h0, 32'h0, 1'b0);
    get_resp(0);

    // npc writes rejected while running
    send(1'b1, 16'h0040, 32'h12345678, 32'h0, 1'b1);
    get_resp(0);
    send(1'b1, 16'h0041, 32'h7f, 32'h0, 1'b1);
    get_resp(0);
    chk("npc_unchanged", npc_o, 39'h0180001000);

    // remaining local registers: write then read back
    for (int i = 0; i < 5; i++) begin
      send(1'b1, la[i], lw[i], 32'h0, 1'b0);
      get_resp(0);
      send(1'b0, la[i], 32'h0, lr[i], 1'b0);
      get_resp(0);
    end
    chk("core_id_o", core_id_o, 4'h3);
    chk("icache_o", icache_mode_o, 2'h2);
    chk("dcache_o", dcache_mode_o, 2'h1);
    chk("cce_o", cce_mode_o, 1'b1);
    chk("reset_o_cleared", reset_o, 0);

    // unmapped offsets
    c0 = fwd_cnt;
    send(1'b0, 16'h0090, 32'h0, 32'h0, 1'b1);
    get_resp(0);
    send(1'b1, 16'h0003, 32'hffffffff, 32'h0, 1'b1);
    get_resp(0);
    send(1'b0, 16'h0070, 32'h0, 32'h0, 1'b1);
    get_resp(0);
    chk("unmapped_no_fwd", fwd_cnt - c0, 0);

    // csr read with stalled target, then held response
    send(1'b0, 16'h6123, 32'h0, 32'hdeadbeef, 1'b0);
    fwd_serve(2'd2, 12'h123, 1'b0, 32'h0, 3, 32'hdeadbeef);
    get_resp(5);

    // other forward targets and range edges
    send(1'b1, 16'h0055, 32'h00000abc, 32'h0, 1'b0);
    fwd_serve(2'd0, 12'h005, 1'b1, 32'h00000abc, 0, 32'h0);
    get_resp(0);
    send(1'b0, 16'h00bf, 32'h0, 32'h13572468, 1'b0);
    fwd_serve(2'd1, 12'h01f, 1'b0, 32'h0, 1, 32'h13572468);
    get_resp(1);
    send(1'b1, 16'h8fff, 32'hcafef00d, 32'h0, 1'b0);
    fwd_serve(2'd3, 12'hfff, 1'b1, 32'hcafef00d, 2, 32'h0);
    get_resp(0);

    // stray read data outside e_fwd_wait is ignored
    fwd_rdata_v_i = 1'b1; fwd_rdata_i = 32'h55555555;
    @(posedge clk); #1;
    fwd_rdata_v_i = 1'b0;
    chk("stray_rdata_no_resp", cfg_if.resp_v, 0);
    chk("stray_rdata_ready", cfg_if.cfg_ready, 1);

    // reset while waiting for forwarded read data
    send(1'b0, 16'h8010, 32'h0, 32'h0, 1'b0);
    chk("pre_rst_fwd_v", fwd_v_o, 1);
    fwd_ready_i = 1'b1;
    @(posedge clk); #1;
    fwd_ready_i = 1'b0;
    chk("in_fwd_wait", cfg_if.cfg_ready | fwd_v_o | cfg_if.resp_v, 0);
    reset_i = 1'b1;
    #1;
    chk("mid_rst_reset_o", reset_o, 1);
    chk("mid_rst_freeze", freeze_o, 1);
    chk("mid_rst_core_id", core_id_o, 0);
    chk("mid_rst_icache", icache_mode_o, 0);
    chk("mid_rst_dcache", dcache_mode_o, 0);
    chk("mid_rst_cce", cce_mode_o, 0);
    chk("mid_rst_npc", npc_o, NPC_RST);
    chk("mid_rst_fwd_v", fwd_v_o, 0);
    chk("mid_rst_resp_v", cfg_if.resp_v, 0);
    chk("mid_rst_ready", cfg_if.cfg_ready, 1);
    sb.delete();
    @(posedge clk); #1;
    reset_i = 1'b0;
    fwd_rdata_v_i = 1'b1; fwd_rdata_i = 32'hbadbad00;
    any_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      fwd_rdata_v_i = 1'b0;
      any_resp = any_resp | cfg_if.resp_v;
    end
    chk("late_rdata_ignored", any_resp, 0);
    chk("post_rst_ready", cfg_if.cfg_ready, 1);

    // decoder still usable after reset
    send(1'b0, 16'h0041, 32'h0, 32'h00, 1'b0);
    get_resp(0);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
